// File: rtl/ysyx_24110015_csr_trap_ctrl_pkg.sv
// Shared definitions for the CSR / trap control slice: op codes, CSR
// addresses, mstatus field positions and the control FSM state type.
package ysyx_24110015_csr_trap_ctrl_pkg;

  typedef enum logic [2:0] {
    OP_CSRRW = 3'd0,
    OP_CSRRS = 3'd1,
    OP_CSRRC = 3'd2,
    OP_ECALL = 3'd3,
    OP_MRET  = 3'd4
  } op_e;

  localparam logic [11:0] ADDR_MSTATUS = 12'h300;
  localparam logic [11:0] ADDR_MTVEC   = 12'h305;
  localparam logic [11:0] ADDR_MEPC    = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE  = 12'h342;

  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;

  // Bit order of the packed write-enable vector used between sub-modules
  localparam int CSR_MSTATUS = 0;
  localparam int CSR_MTVEC   = 1;
  localparam int CSR_MEPC    = 2;
  localparam int CSR_MCAUSE  = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/ysyx_24110015_csr_trap_ctrl_if.sv
// Request/response channel between the pipeline and the CSR/trap unit.
interface ysyx_24110015_csr_trap_ctrl_if;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_op;
  logic [11:0] in_addr;
  logic [31:0] in_src;
  logic [31:0] in_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_rdata;
  logic        out_redirect;
  logic [31:0] out_npc;
  logic        out_illegal;

  modport master (
    output in_valid, in_op, in_addr, in_src, in_pc, out_ready,
    input  in_ready, out_valid, out_rdata, out_redirect, out_npc, out_illegal
  );

  modport slave (
    input  in_valid, in_op, in_addr, in_src, in_pc, out_ready,
    output in_ready, out_valid, out_rdata, out_redirect, out_npc, out_illegal
  );
endinterface

// File: rtl/ysyx_24110015_csr_wdata.sv
// Combinational CSR write-data / result computation for one latched request.
module ysyx_24110015_csr_wdata
  import ysyx_24110015_csr_trap_ctrl_pkg::*;
#(
  parameter logic [31:0] MCAUSE_ECALL  = 32'd11,
  parameter logic [1:0]  MSTATUS_MPP_M = 2'b11
) (
  input  logic [2:0]  op,
  input  logic [11:0] addr,
  input  logic [31:0] src,
  input  logic [31:0] pc,
  input  logic [31:0] mstatus_q,
  input  logic [31:0] mtvec_q,
  input  logic [31:0] mepc_q,
  input  logic [31:0] mcause_q,
  output logic [31:0] mstatus_d,
  output logic [31:0] mtvec_d,
  output logic [31:0] mepc_d,
  output logic [31:0] mcause_d,
  output logic [3:0]  we,
  output logic [31:0] rdata,
  output logic [31:0] npc,
  output logic        redirect,
  output logic        illegal
);

  logic [3:0]  sel;
  logic [31:0] old_val;
  logic [31:0] new_val;
  logic        wr_ok;
  logic [31:0] ecall_mstatus;
  logic [31:0] mret_mstatus;

  // Address decode and read-modify-write value for the CSRRx ops
  always_comb begin
    sel     = 4'b0000;
    old_val = 32'd0;
    case (addr)
      ADDR_MSTATUS: begin sel = 4'b0001; old_val = mstatus_q; end
      ADDR_MTVEC:   begin sel = 4'b0010; old_val = mtvec_q;   end
      ADDR_MEPC:    begin sel = 4'b0100; old_val = mepc_q;    end
      ADDR_MCAUSE:  begin sel = 4'b1000; old_val = mcause_q;  end
      default:      begin sel = 4'b0000; old_val = 32'd0;     end
    endcase
    new_val = src;
    wr_ok   = 1'b1;
    if (op == OP_CSRRS) begin
      new_val = old_val | src;
      wr_ok   = (src != 32'd0);
    end else if (op == OP_CSRRC) begin
      new_val = old_val & ~src;
      wr_ok   = (src != 32'd0);
    end
  end

  // Trap entry / return mstatus images; untouched fields pass through
  always_comb begin
    ecall_mstatus = mstatus_q;
    ecall_mstatus[MSTATUS_MPIE] = mstatus_q[MSTATUS_MIE];
    ecall_mstatus[MSTATUS_MIE]  = 1'b0;
    ecall_mstatus[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = MSTATUS_MPP_M;
    mret_mstatus = mstatus_q;
    mret_mstatus[MSTATUS_MIE]  = mstatus_q[MSTATUS_MPIE];
    mret_mstatus[MSTATUS_MPIE] = 1'b1;
    mret_mstatus[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = MSTATUS_MPP_M;
  end

  // Per-op selection of write data, enables and the response fields
  always_comb begin
    mstatus_d = mstatus_q;
    mtvec_d   = mtvec_q;
    mepc_d    = mepc_q;
    mcause_d  = mcause_q;
    we        = 4'b0000;
    rdata     = 32'd0;
    npc       = 32'd0;
    redirect  = 1'b0;
    illegal   = 1'b0;
    case (op)
      OP_CSRRW, OP_CSRRS, OP_CSRRC: begin
        if (sel == 4'b0000) begin
          illegal = 1'b1;
        end else begin
          rdata = old_val;
          if (wr_ok) we = sel;
          if (sel[CSR_MSTATUS]) mstatus_d = new_val;
          if (sel[CSR_MTVEC])   mtvec_d   = new_val;
          if (sel[CSR_MEPC])    mepc_d    = new_val;
          if (sel[CSR_MCAUSE])  mcause_d  = new_val;
        end
      end
      OP_ECALL: begin
        mstatus_d = ecall_mstatus;
        mepc_d    = pc;
        mcause_d  = MCAUSE_ECALL;
        we        = 4'b1101;
        redirect  = 1'b1;
        npc       = {mtvec_q[31:2], 2'b00};
      end
      OP_MRET: begin
        mstatus_d = mret_mstatus;
        we        = 4'b0001;
        redirect  = 1'b1;
        npc       = mepc_q;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/ysyx_24110015_csr_trap_ctrl.sv
// CSR access / ECALL / MRET control: IDLE -> EXEC (one-cycle CSR write) ->
// RESP (held until consumed). One request in flight at a time.
module ysyx_24110015_csr_trap_ctrl
  import ysyx_24110015_csr_trap_ctrl_pkg::*;
#(
  parameter logic [31:0] MCAUSE_ECALL  = 32'd11,
  parameter logic [1:0]  MSTATUS_MPP_M = 2'b11
) (
  input  logic                          clk,
  input  logic                          rst,
  ysyx_24110015_csr_trap_ctrl_if.slave  bus,
  input  logic [31:0]                   csr_mstatus_q,
  input  logic [31:0]                   csr_mtvec_q,
  input  logic [31:0]                   csr_mepc_q,
  input  logic [31:0]                   csr_mcause_q,
  output logic [31:0]                   csr_mstatus_d,
  output logic [31:0]                   csr_mtvec_d,
  output logic [31:0]                   csr_mepc_d,
  output logic [31:0]                   csr_mcause_d,
  output logic                          csr_mstatus_we,
  output logic                          csr_mtvec_we,
  output logic                          csr_mepc_we,
  output logic                          csr_mcause_we
);

  state_e      state_reg, state_next;
  logic [2:0]  op_reg;
  logic [11:0] addr_reg;
  logic [31:0] src_reg;
  logic [31:0] pc_reg;
  logic [31:0] rdata_reg;
  logic [31:0] npc_reg;
  logic        redirect_reg;
  logic        illegal_reg;

  logic [3:0]  wd_we;
  logic [31:0] wd_rdata;
  logic [31:0] wd_npc;
  logic        wd_redirect;
  logic        wd_illegal;
  logic [3:0]  we_gated;

  ysyx_24110015_csr_wdata #(
    .MCAUSE_ECALL  (MCAUSE_ECALL),
    .MSTATUS_MPP_M (MSTATUS_MPP_M)
  ) u_wdata (
    .op        (op_reg),
    .addr      (addr_reg),
    .src       (src_reg),
    .pc        (pc_reg),
    .mstatus_q (csr_mstatus_q),
    .mtvec_q   (csr_mtvec_q),
    .mepc_q    (csr_mepc_q),
    .mcause_q  (csr_mcause_q),
    .mstatus_d (csr_mstatus_d),
    .mtvec_d   (csr_mtvec_d),
    .mepc_d    (csr_mepc_d),
    .mcause_d  (csr_mcause_d),
    .we        (wd_we),
    .rdata     (wd_rdata),
    .npc       (wd_npc),
    .redirect  (wd_redirect),
    .illegal   (wd_illegal)
  );

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state_reg <= ST_IDLE;
    else     state_reg <= state_next;
  end

  // FSM next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (bus.in_valid) state_next = ST_EXEC;
      ST_EXEC: state_next = ST_RESP;
      ST_RESP: if (bus.out_ready) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Request latch on the accept handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      op_reg   <= 3'd0;
      addr_reg <= 12'd0;
      src_reg  <= 32'd0;
      pc_reg   <= 32'd0;
    end else if (state_reg == ST_IDLE && bus.in_valid) begin
      op_reg   <= bus.in_op;
      addr_reg <= bus.in_addr;
      src_reg  <= bus.in_src;
      pc_reg   <= bus.in_pc;
    end
  end

  // Result capture at the end of EXEC; rdata reflects the pre-write value
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_reg    <= 32'd0;
      npc_reg      <= 32'd0;
      redirect_reg <= 1'b0;
      illegal_reg  <= 1'b0;
    end else if (state_reg == ST_EXEC) begin
      rdata_reg    <= wd_rdata;
      npc_reg      <= wd_npc;
      redirect_reg <= wd_redirect;
      illegal_reg  <= wd_illegal;
    end
  end

  // FSM outputs; write enables are suppressed while rst is high so an
  // aborted EXEC never commits anything
  always_comb begin
    bus.in_ready     = (state_reg == ST_IDLE);
    bus.out_valid    = (state_reg == ST_RESP);
    bus.out_rdata    = rdata_reg;
    bus.out_npc      = npc_reg;
    bus.out_redirect = redirect_reg;
    bus.out_illegal  = illegal_reg;
    we_gated         = (state_reg == ST_EXEC && !rst) ? wd_we : 4'b0000;
    csr_mstatus_we   = we_gated[CSR_MSTATUS];
    csr_mtvec_we     = we_gated[CSR_MTVEC];
    csr_mepc_we      = we_gated[CSR_MEPC];
    csr_mcause_we    = we_gated[CSR_MCAUSE];
  end

endmodule

// File: tb/tb_ysyx_24110015_csr_trap_ctrl.sv
// Bench for the CSR/trap controller: directed cases, a reset abort and a
// randomized run, each checked against a spec-level reference model.
module tb_ysyx_24110015_csr_trap_ctrl;

  typedef logic [31:0] csr_arr_t [4];
  localparam logic [11:0] ADDRS [4] = '{12'h300, 12'h305, 12'h341, 12'h342};

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ysyx_24110015_csr_trap_ctrl_if bus();

  // CSR file held by the bench: index 0 mstatus, 1 mtvec, 2 mepc, 3 mcause
  csr_arr_t    csr_q;
  csr_arr_t    ld_val;
  logic        ld_en = 1'b0;
  logic [31:0] d_mstatus, d_mtvec, d_mepc, d_mcause;
  logic        we_mstatus, we_mtvec, we_mepc, we_mcause;
  logic [3:0]  we_vec;
  logic [31:0] d_vec [4];

  assign we_vec = {we_mcause, we_mepc, we_mtvec, we_mstatus};
  assign d_vec[0] = d_mstatus;
  assign d_vec[1] = d_mtvec;
  assign d_vec[2] = d_mepc;
  assign d_vec[3] = d_mcause;

  int total = 0;
  int bad   = 0;

  ysyx_24110015_csr_trap_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .bus            (bus),
    .csr_mstatus_q  (csr_q[0]),
    .csr_mtvec_q    (csr_q[1]),
    .csr_mepc_q     (csr_q[2]),
    .csr_mcause_q   (csr_q[3]),
    .csr_mstatus_d  (d_mstatus),
    .csr_mtvec_d    (d_mtvec),
    .csr_mepc_d     (d_mepc),
    .csr_mcause_d   (d_mcause),
    .csr_mstatus_we (we_mstatus),
    .csr_mtvec_we   (we_mtvec),
    .csr_mepc_we    (we_mepc),
    .csr_mcause_we  (we_mcause)
  );

  // CSR file: bench preload or DUT write enables
  always @(posedge clk) begin
    if (ld_en) begin
      for (int i = 0; i < 4; i++) csr_q[i] <= ld_val[i];
    end else begin
      for (int i = 0; i < 4; i++) if (we_vec[i]) csr_q[i] <= d_vec[i];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model: architectural effect of one request on the CSR set
  task automatic ref_model(input logic [2:0] op, input logic [11:0] addr,
                           input logic [31:0] src, input logic [31:0] pc,
                           input csr_arr_t cur, output csr_arr_t nxt,
                           output logic [3:0] wm, output logic [31:0] rd,
                           output logic [31:0] npc, output logic red,
                           output logic ill);
    int idx;
    idx = -1;
    for (int i = 0; i < 4; i++) if (addr == ADDRS[i]) idx = i;
    nxt = cur; wm = 4'd0; rd = 32'd0; npc = 32'd0; red = 1'b0; ill = 1'b0;
    if (op <= 3'd2) begin
      if (idx < 0) ill = 1'b1;
      else begin
        rd = cur[idx];
        if (op == 3'd0) begin
          nxt[idx] = src; wm[idx] = 1'b1;
        end else if (src != 0) begin
          nxt[idx] = (op == 3'd1) ? (cur[idx] | src) : (cur[idx] & ~src);
          wm[idx] = 1'b1;
        end
      end
    end else if (op == 3'd3) begin
      nxt[0] = (cur[0] & ~32'h1888) | (cur[0][3] ? 32'h80 : 32'h0) | 32'h1800;
      nxt[2] = pc;
      nxt[3] = 32'd11;
      wm = 4'b1101; red = 1'b1; npc = cur[1] & ~32'h3;
    end else if (op == 3'd4) begin
      nxt[0] = (cur[0] & ~32'h1888) | (cur[0][7] ? 32'h8 : 32'h0) | 32'h1880;
      wm = 4'b0001; red = 1'b1; npc = cur[2];
    end else begin
      ill = 1'b1;
    end
  endtask

  task automatic load_csr(input logic [31:0] ms, input logic [31:0] tv,
                          input logic [31:0] ep, input logic [31:0] mc);
    ld_val[0] = ms; ld_val[1] = tv; ld_val[2] = ep; ld_val[3] = mc;
    ld_en = 1'b1;
    @(posedge clk); #1;
    ld_en = 1'b0;
  endtask

  task automatic check_resp(input string tag, input logic [31:0] rd, input logic [31:0] npc,
                            input logic red, input logic ill);
    chk({tag, "_valid"}, {31'd0, bus.out_valid}, 32'd1);
    chk({tag, "_in_ready"}, {31'd0, bus.in_ready}, 32'd0);
    chk({tag, "_rdata"}, bus.out_rdata, rd);
    chk({tag, "_npc"}, bus.out_npc, npc);
    chk({tag, "_redirect"}, {31'd0, bus.out_redirect}, {31'd0, red});
    chk({tag, "_illegal"}, {31'd0, bus.out_illegal}, {31'd0, ill});
  endtask

  // One full request/response; called at posedge+1 with the DUT idle
  task automatic txn(input logic [2:0] op, input logic [11:0] addr,
                     input logic [31:0] src, input logic [31:0] pc, input int hold);
    csr_arr_t    cur, nxt;
    logic [3:0]  wm;
    logic [31:0] rd, npc;
    logic        red, ill;
    cur = csr_q;
    ref_model(op, addr, src, pc, cur, nxt, wm, rd, npc, red, ill);
    chk("idle_in_ready", {31'd0, bus.in_ready}, 32'd1);
    bus.in_valid = 1'b1; bus.in_op = op; bus.in_addr = addr;
    bus.in_src = src; bus.in_pc = pc;
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.in_src = $urandom; bus.in_pc = $urandom;
    chk("exec_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("exec_in_ready", {31'd0, bus.in_ready}, 32'd0);
    chk("exec_we", {28'd0, we_vec}, {28'd0, wm});
    for (int i = 0; i < 4; i++) if (wm[i]) chk("exec_d", d_vec[i], nxt[i]);
    @(posedge clk); #1;
    chk("resp_we", {28'd0, we_vec}, 32'd0);
    for (int i = 0; i < 4; i++) chk("csr_after", csr_q[i], nxt[i]);
    check_resp("resp", rd, npc, red, ill);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      check_resp("hold", rd, npc, red, ill);
      chk("hold_we", {28'd0, we_vec}, 32'd0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk("done_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("done_in_ready", {31'd0, bus.in_ready}, 32'd1);
    $display("txn op=%0d addr=%h src=%h pc=%h rdata=%h redirect=%0b npc=%h illegal=%0b hold=%0d",
             op, addr, src, pc, bus.out_rdata, bus.out_redirect, bus.out_npc, bus.out_illegal, hold);
  endtask

  initial begin
    csr_arr_t snap;
    bus.in_valid = 1'b0; bus.in_op = 3'd0; bus.in_addr = 12'd0;
    bus.in_src = 32'd0; bus.in_pc = 32'd0; bus.out_ready = 1'b0;
    ld_val[0] = 32'h0000_1808; ld_val[1] = 32'd0; ld_val[2] = 32'd0; ld_val[3] = 32'h0000_000B;
    ld_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    ld_en = 1'b0;
    chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_redirect", {31'd0, bus.out_redirect}, 32'd0);
    chk("rst_illegal", {31'd0, bus.out_illegal}, 32'd0);
    chk("rst_rdata", bus.out_rdata, 32'd0);
    chk("rst_npc", bus.out_npc, 32'd0);
    chk("rst_we", {28'd0, we_vec}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed cases
    txn(3'd0, 12'h305, 32'h8000_0100, 32'h8000_0000, 0);
    load_csr(32'h0000_1808, 32'h8000_0100, 32'd0, 32'd0);
    txn(3'd3, 12'h000, 32'd0, 32'h8000_0040, 1);
    load_csr(32'h0000_1880, 32'h8000_0100, 32'h8000_0044, 32'd11);
    txn(3'd4, 12'h000, 32'd0, 32'h8000_0050, 0);
    load_csr(32'h0000_1888, 32'h8000_0100, 32'h8000_0044, 32'h0000_000B);
    txn(3'd1, 12'h300, 32'd0, 32'd0, 0);
    txn(3'd2, 12'h342, 32'h0000_000F, 32'd0, 0);
    txn(3'd0, 12'h7C0, 32'h1234_5678, 32'd0, 3);
    txn(3'd0, 12'h341, 32'hDEAD_BEEF, 32'd0, 0);
    txn(3'd6, 12'h300, 32'hFFFF_FFFF, 32'd0, 1);
    txn(3'd3, 12'h000, 32'd0, 32'h8000_1000, 0);

    // Reset pulse while in EXEC aborts the operation
    load_csr(32'h0000_0008, 32'h8000_0200, 32'h1, 32'h2);
    snap = csr_q;
    bus.in_valid = 1'b1; bus.in_op = 3'd3; bus.in_addr = 12'd0;
    bus.in_src = 32'd0; bus.in_pc = 32'h8000_0300;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("abort_we_in_rst", {28'd0, we_vec}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_we", {28'd0, we_vec}, 32'd0);
    chk("abort_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("abort_in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("abort_redirect", {31'd0, bus.out_redirect}, 32'd0);
    for (int i = 0; i < 4; i++) chk("abort_csr", csr_q[i], snap[i]);
    @(posedge clk); #1;
    chk("abort_idle_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("abort_idle_we", {28'd0, we_vec}, 32'd0);
    $display("txn reset-abort during EXEC out_valid=%0b in_ready=%0b", bus.out_valid, bus.in_ready);

    // Randomized requests
    for (int n = 0; n < 60; n++) begin
      logic [11:0] a;
      logic [31:0] s;
      int r;
      if (n % 4 == 0) load_csr($urandom, $urandom, $urandom, $urandom);
      r = $urandom_range(0, 4);
      a = (r < 4) ? ADDRS[r] : 12'($urandom);
      s = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      txn(3'($urandom_range(0, 7)), a, s, $urandom, $urandom_range(0, 2));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global guard so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ysyx_24110015_csr_trap_ctrl.md
YSYX_24110015_CSR_TRAP_CTRL -- requirements
Module: ysyx_24110015_csr_trap_ctrl

Interface
REQ-001 SHALL have parameter: MCAUSE_ECALL, default 32'd11, cause code written on ECALL.
REQ-002 SHALL have parameter: MSTATUS_MPP_M, default 2'b11, MPP value written on ECALL and MRET.
REQ-003 SHALL have ports, clock and reset first:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  request valid.
- in_ready  out  1  request accepted when in_valid & in_ready.
- in_op  in  3  operation: 0 CSRRW, 1 CSRRS, 2 CSRRC, 3 ECALL, 4 MRET; 5-7 reserved.
- in_addr  in  12  CSR address.
- in_src  in  32  rs1 value.
- in_pc  in  32  pc of requesting instruction.
- out_valid  out  1  result valid.
- out_ready  in  1  result consumed when out_valid & out_ready.
- out_rdata  out  32  old CSR value (rd writeback).
- out_redirect  out  1  pc redirect required.
- out_npc  out  32  redirect target.
- out_illegal  out  1  unsupported address or reserved op.
- csr_mstatus/mtvec/mepc/mcause_q  in  32 each  current CSR-file contents.
- csr_*_d  out  32 each  write data to CSR file, same four registers.
- csr_*_we  out  1 each  write enables to CSR file, same four registers.

Function
REQ-004 SHALL implement FSM IDLE -> EXEC -> RESP -> IDLE; in_ready=1 only in IDLE.
REQ-005 On handshake in IDLE, SHALL latch op/addr/src/pc and go to EXEC.
REQ-006 In EXEC (exactly one cycle), SHALL select old value from csr_*_q, compute write data, pulse the relevant csr_*_we for that cycle only, capture result, go to RESP.
REQ-007 Address map: 0x300 mstatus, 0x305 mtvec, 0x341 mepc, 0x342 mcause; any other address SHALL set out_illegal=1, out_rdata=0, and produce no write.
REQ-008 CSRRW SHALL write in_src; CSRRS SHALL write old|src; CSRRC SHALL write old&~src; CSRRS/CSRRC with src==0 SHALL NOT assert any we.
REQ-009 ECALL SHALL write mepc=pc, mcause=MCAUSE_ECALL, mstatus with MPIE(bit7)=old MIE(bit3), MIE=0, MPP(bits12:11)=MSTATUS_MPP_M, all in the same EXEC cycle; out_redirect=1, out_npc={mtvec_q[31:2],2'b00}, out_rdata=0.
REQ-010 MRET SHALL write mstatus with MIE=old MPIE, MPIE=1, MPP=MSTATUS_MPP_M; out_redirect=1, out_npc=mepc_q; out_rdata=0.
REQ-011 Reserved op SHALL set out_illegal=1 with no writes and no redirect.
REQ-012 In RESP, out_valid=1; outputs held stable until out_ready; on handshake SHALL return to IDLE; in_ready stays 0 in RESP (no overlap).
REQ-013 Latency: accept at cycle N, CSR write at edge ending N+1, out_valid from N+2; a back-to-back request is accepted no earlier than the cycle after the response handshake.
REQ-014 out_rdata SHALL be the pre-write value, so CSRRW to the same CSR returns the old value.
REQ-015 Bits of mstatus other than 3, 7, 12:11 SHALL be preserved on ECALL/MRET.

Reset
REQ-016 rst SHALL force state IDLE, in_ready=1, out_valid=0, out_redirect=0, out_illegal=0, out_rdata=0, out_npc=0, all csr_*_we=0.
REQ-017 rst asserted in EXEC or RESP SHALL abort the operation: no we pulse after the reset edge, response discarded.

Structure
REQ-018 Shared package SHALL hold op encodings, the four CSR addresses, mstatus bit positions, and the FSM state enum.
REQ-019 Write-data computation (RW/RS/RC/ECALL/MRET mstatus update) SHALL be one combinational sub-module, ysyx_24110015_csr_wdata.

Verification
REQ-020 CSRRW 0x305 src=0x80000100 with mtvec_q=0 -> mtvec_we pulse with d=0x80000100; out_rdata=0 at N+2.
REQ-021 ECALL pc=0x80000040, mstatus_q=0x00001808, mtvec_q=0x80000100 -> mepc=0x80000040, mcause=11, mstatus=0x00001880, npc=0x80000100, redirect=1.
REQ-022 MRET with mstatus_q=0x00001880, mepc_q=0x80000044 -> mstatus=0x00001888, npc=0x80000044.
REQ-023 CSRRS 0x300 src=0 -> no we; out_rdata=mstatus_q; CSRRC 0x342 src=0xF on mcause_q=0xB -> d=0x0, rdata=0xB.
REQ-024 CSRRW 0x7C0 -> out_illegal=1, no we; out_ready held 0 for 3 cycles -> outputs stable, in_ready=0.
REQ-025 rst pulse in EXEC -> no we after the reset edge, out_valid=0, IDLE next cycle.
